// File: rtl/emergency_pkg.sv
// Shared FSM encodings and default timing constants for the multi-zone
// emergency controller.
package emergency_pkg;

  typedef enum logic [1:0] {
    INACTIVE       = 2'd0,
    EMERGENCY      = 2'd1,
    SILENCED       = 2'd2,
    POST_EMERGENCY = 2'd3
  } state_e;

  localparam int unsigned DEF_NZONES          = 4;
  localparam int unsigned DEF_EMERG_CYCLES    = 5_000_000;
  localparam int unsigned DEF_RECOV_CYCLES    = 10_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50_000;
  localparam int unsigned DEF_TIMER_W         = 25;
  localparam int unsigned DEF_FAST_BIT        = 22;
  localparam int unsigned DEF_SLOW_BIT        = 21;

endpackage

// File: rtl/zone_debounce.sv
// One panic input: 2-FF synchroniser, hold-time debounce and a single-cycle
// pulse on the accepted 0->1 transition.
module zone_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             s1_q, s2_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;

  assign done = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Counter only runs while the synchronised level disagrees with the
  // accepted level; any return to agreement restarts the hold window.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (done) deb_d = s2_q;
      else      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign rise_o = s2_q & ~deb_q & done;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= async_i;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multi_zone_emergency.sv
// Multi-zone emergency controller: per-zone panic/danger inputs feed a
// four-state alarm FSM with dwell timers and registered actuator outputs.
module multi_zone_emergency
  import emergency_pkg::*;
#(
  parameter int unsigned NZONES          = DEF_NZONES,
  parameter int unsigned EMERG_CYCLES    = DEF_EMERG_CYCLES,
  parameter int unsigned RECOV_CYCLES    = DEF_RECOV_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TIMER_W         = DEF_TIMER_W,
  parameter int unsigned FAST_BIT        = DEF_FAST_BIT,
  parameter int unsigned SLOW_BIT        = DEF_SLOW_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NZONES-1:0] panic_btn,
  input  logic [NZONES-1:0] danger_sense,
  input  logic              ack,
  output logic              alarm,
  output logic              alert_light,
  output logic [NZONES-1:0] door_unlock,
  output logic              call_help,
  output logic [NZONES-1:0] active_zones,
  output logic [1:0]        state_o
);

  logic [NZONES-1:0]  panic_ev, dng_s1_q, dng_s2_q;
  logic [NZONES-1:0]  zone_ev, new_ev;
  logic [NZONES-1:0]  active_q, active_d;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               rearm, any_ev, any_new, danger_any, emerg_to, recov_to;
  logic               alarm_d, light_d, call_d;
  logic [NZONES-1:0]  door_d;

  for (genvar z = 0; z < NZONES; z++) begin : g_zone
    zone_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk     (clk),
      .reset   (reset),
      .async_i (panic_btn[z]),
      .rise_o  (panic_ev[z])
    );
  end

  assign zone_ev    = panic_ev | dng_s2_q;
  assign new_ev     = zone_ev & ~active_q;
  assign any_ev     = |zone_ev;
  assign any_new    = |new_ev;
  assign danger_any = |dng_s2_q;
  assign emerg_to   = (timer_q >= TIMER_W'(EMERG_CYCLES - 1)) && !danger_any;
  assign recov_to   = (timer_q >= TIMER_W'(RECOV_CYCLES - 1));

  // Events outrank ack, ack outranks timeout; a new zone while already in
  // EMERGENCY restarts the dwell rather than allowing ack/timeout through.
  always_comb begin
    state_d = state_q;
    rearm   = 1'b0;
    case (state_q)
      INACTIVE:       if (any_ev) state_d = EMERGENCY;
      EMERGENCY: begin
        if (any_new)       rearm   = 1'b1;
        else if (ack)      state_d = SILENCED;
        else if (emerg_to) state_d = POST_EMERGENCY;
      end
      SILENCED: begin
        if (any_new)       state_d = EMERGENCY;
        else if (emerg_to) state_d = POST_EMERGENCY;
      end
      POST_EMERGENCY: begin
        if (any_ev)        state_d = EMERGENCY;
        else if (recov_to) state_d = INACTIVE;
      end
      default:             state_d = INACTIVE;
    endcase
  end

  always_comb begin
    if ((state_d != state_q) || rearm) timer_d = '0;
    else if (&timer_q)                 timer_d = timer_q;
    else                               timer_d = timer_q + TIMER_W'(1);
  end

  assign active_d = (state_d == INACTIVE) ? '0 : (active_q | zone_ev);

  always_comb begin
    alarm_d = 1'b0;
    light_d = 1'b0;
    call_d  = 1'b0;
    door_d  = '0;
    case (state_q)
      EMERGENCY: begin
        alarm_d = ~timer_q[FAST_BIT];
        light_d = 1'b1;
        call_d  = 1'b1;
        door_d  = active_q;
      end
      SILENCED: begin
        light_d = 1'b1;
        call_d  = 1'b1;
        door_d  = active_q;
      end
      POST_EMERGENCY: light_d = timer_q[SLOW_BIT];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dng_s1_q    <= '0;
      dng_s2_q    <= '0;
      state_q     <= INACTIVE;
      timer_q     <= '0;
      active_q    <= '0;
      alarm       <= 1'b0;
      alert_light <= 1'b0;
      call_help   <= 1'b0;
      door_unlock <= '0;
    end else begin
      dng_s1_q    <= danger_sense;
      dng_s2_q    <= dng_s1_q;
      state_q     <= state_d;
      timer_q     <= timer_d;
      active_q    <= active_d;
      alarm       <= alarm_d;
      alert_light <= light_d;
      call_help   <= call_d;
      door_unlock <= door_d;
    end
  end

  assign state_o      = state_q;
  assign active_zones = active_q;

endmodule

// File: tb/tb_multi_zone_emergency.sv
// Directed scenario bench for multi_zone_emergency with shortened timing.
module tb_multi_zone_emergency;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] panic_btn, danger_sense;
  logic       ack;
  logic       alarm, alert_light, call_help;
  logic [3:0] door_unlock, active_zones;
  logic [1:0] state_o;

  int tests_run = 0;
  int tests_failed = 0;

  multi_zone_emergency #(
    .NZONES(4), .EMERG_CYCLES(20), .RECOV_CYCLES(40), .DEBOUNCE_CYCLES(4),
    .TIMER_W(8), .FAST_BIT(2), .SLOW_BIT(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .panic_btn    (panic_btn),
    .danger_sense (danger_sense),
    .ack          (ack),
    .alarm        (alarm),
    .alert_light  (alert_light),
    .door_unlock  (door_unlock),
    .call_help    (call_help),
    .active_zones (active_zones),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; panic_btn = '0; danger_sense = '0; ack = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (state_o !== 2'd0) begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    tests_run++;
    if ({alarm, alert_light, call_help, door_unlock} !== 7'b0) begin
      tests_failed++; $display("FAIL reset_outputs got=%b exp=0000000", {alarm, alert_light, call_help, door_unlock});
    end
    tests_run++;
    if (active_zones !== 4'b0) begin tests_failed++; $display("FAIL reset_active got=%b exp=0000", active_zones); end
  endtask

  task automatic test_glitch();
    do_reset();
    panic_btn[1] = 1'b1;
    tick(3);
    panic_btn[1] = 1'b0;
    tick(10);
    tests_run++;
    if (state_o !== 2'd0) begin tests_failed++; $display("FAIL glitch_ignored got=%0d exp=0", state_o); end
    panic_btn[1] = 1'b1;
    tick(5);
    tests_run++;
    if (state_o !== 2'd0) begin tests_failed++; $display("FAIL debounce_early got=%0d exp=0", state_o); end
    tick(1);
    tests_run++;
    if (state_o !== 2'd1) begin tests_failed++; $display("FAIL debounce_state got=%0d exp=1", state_o); end
    tests_run++;
    if (active_zones !== 4'b0010) begin tests_failed++; $display("FAIL debounce_active got=%b exp=0010", active_zones); end
    tests_run++;
    if (door_unlock !== 4'b0000) begin tests_failed++; $display("FAIL door_latency0 got=%b exp=0000", door_unlock); end
    tick(1);
    tests_run++;
    if (door_unlock !== 4'b0010) begin tests_failed++; $display("FAIL door_latency1 got=%b exp=0010", door_unlock); end
    tests_run++;
    if ({alarm, alert_light, call_help} !== 3'b111) begin
      tests_failed++; $display("FAIL emerg_outputs got=%b exp=111", {alarm, alert_light, call_help});
    end
    tick(3);
    panic_btn[1] = 1'b0;
    tick(3);
  endtask

  task automatic test_ack_rearm();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tests_run++;
    if (state_o !== 2'd2) begin tests_failed++; $display("FAIL ack_state got=%0d exp=2", state_o); end
    tick(1);
    tests_run++;
    if (alarm !== 1'b0) begin tests_failed++; $display("FAIL ack_alarm got=%b exp=0", alarm); end
    tests_run++;
    if (door_unlock !== 4'b0010) begin tests_failed++; $display("FAIL ack_door got=%b exp=0010", door_unlock); end
    panic_btn[3] = 1'b1;
    tick(5);
    tests_run++;
    if (state_o !== 2'd2) begin tests_failed++; $display("FAIL rearm_early got=%0d exp=2", state_o); end
    tick(1);
    tests_run++;
    if (state_o !== 2'd1) begin tests_failed++; $display("FAIL rearm_state got=%0d exp=1", state_o); end
    tests_run++;
    if (active_zones !== 4'b1010) begin tests_failed++; $display("FAIL rearm_active got=%b exp=1010", active_zones); end
    tick(1);
    tests_run++;
    if (alarm !== 1'b1) begin tests_failed++; $display("FAIL rearm_alarm got=%b exp=1", alarm); end
    panic_btn[3] = 1'b0;
  endtask

  task automatic test_danger_hold();
    int bad;
    do_reset();
    danger_sense[0] = 1'b1;
    tick(3);
    for (int i = 0; i < 100; i++) begin
      tests_run++;
      if (state_o !== 2'd1) begin
        tests_failed++; $display("FAIL danger_hold cycle=%0d got=%0d exp=1", i, state_o);
      end
      tick(1);
    end
    danger_sense[0] = 1'b0;
    tick(2);
    tests_run++;
    if (state_o !== 2'd1) begin tests_failed++; $display("FAIL danger_release_sync got=%0d exp=1", state_o); end
    tick(1);
    tests_run++;
    if (state_o !== 2'd3) begin tests_failed++; $display("FAIL post_entry got=%0d exp=3", state_o); end
    tick(1);
    tests_run++;
    if ({alert_light, call_help} !== 2'b00) begin
      tests_failed++; $display("FAIL post_outputs got=%b exp=00", {alert_light, call_help});
    end
    tick(8);
    tests_run++;
    if (alert_light !== 1'b1) begin tests_failed++; $display("FAIL post_blink got=%b exp=1", alert_light); end
    tests_run++;
    if (active_zones !== 4'b0001) begin tests_failed++; $display("FAIL post_active got=%b exp=0001", active_zones); end
    tick(30);
    tests_run++;
    if (state_o !== 2'd3) begin tests_failed++; $display("FAIL recov_early got=%0d exp=3", state_o); end
    tick(1);
    bad = (state_o !== 2'd0) || (active_zones !== 4'b0);
    tests_run++;
    if (bad != 0) begin
      tests_failed++; $display("FAIL recov_inactive got=%0d/%b exp=0/0000", state_o, active_zones);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    danger_sense[0] = 1'b1;
    tick(1);
    danger_sense[0] = 1'b0;
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tests_run++;
    if (state_o !== 2'd2) begin tests_failed++; $display("FAIL simul_setup got=%0d exp=2", state_o); end
    tick(14);
    panic_btn[2] = 1'b1;
    tick(5);
    tests_run++;
    if (state_o !== 2'd2) begin tests_failed++; $display("FAIL simul_pre got=%0d exp=2", state_o); end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    panic_btn[2] = 1'b0;
    tests_run++;
    if (state_o !== 2'd1) begin tests_failed++; $display("FAIL simul_event_wins got=%0d exp=1", state_o); end
    tests_run++;
    if (active_zones !== 4'b0101) begin tests_failed++; $display("FAIL simul_active got=%b exp=0101", active_zones); end
    tick(19);
    tests_run++;
    if (state_o !== 2'd1) begin tests_failed++; $display("FAIL emerg_dwell got=%0d exp=1", state_o); end
    tick(1);
    tests_run++;
    if (state_o !== 2'd3) begin tests_failed++; $display("FAIL emerg_timeout got=%0d exp=3", state_o); end
    danger_sense[3] = 1'b1;
    tick(2);
    tests_run++;
    if (state_o !== 2'd3) begin tests_failed++; $display("FAIL post_danger_sync got=%0d exp=3", state_o); end
    tick(1);
    tests_run++;
    if (state_o !== 2'd1) begin tests_failed++; $display("FAIL post_danger_return got=%0d exp=1", state_o); end
    tests_run++;
    if (active_zones !== 4'b1101) begin tests_failed++; $display("FAIL post_danger_active got=%b exp=1101", active_zones); end
    danger_sense[3] = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    danger_sense = 4'b0111;
    tick(1);
    danger_sense = 4'b0000;
    tick(2);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(1);
    tests_run++;
    if ({state_o, door_unlock, alert_light, call_help} !== {2'd2, 4'b0111, 2'b11}) begin
      tests_failed++;
      $display("FAIL mid_setup got=%0d/%b/%b%b exp=2/0111/11", state_o, door_unlock, alert_light, call_help);
    end
    panic_btn[0] = 1'b1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tests_run++;
    if (state_o !== 2'd0) begin tests_failed++; $display("FAIL mid_reset_state got=%0d exp=0", state_o); end
    tests_run++;
    if ({alarm, alert_light, call_help, door_unlock, active_zones} !== 11'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs got=%b exp=0", {alarm, alert_light, call_help, door_unlock, active_zones});
    end
    tick(5);
    tests_run++;
    if (state_o !== 2'd0) begin tests_failed++; $display("FAIL held_panic_early got=%0d exp=0", state_o); end
    tick(1);
    tests_run++;
    if (state_o !== 2'd1) begin tests_failed++; $display("FAIL held_panic_state got=%0d exp=1", state_o); end
    tests_run++;
    if (active_zones !== 4'b0001) begin tests_failed++; $display("FAIL held_panic_active got=%b exp=0001", active_zones); end
    panic_btn[0] = 1'b0;
  endtask

  initial begin
    reset = 1'b1; panic_btn = '0; danger_sense = '0; ack = 1'b0;
    test_reset();
    test_glitch();
    test_ack_rearm();
    test_danger_hold();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
